multi_mode_reg_array: RTL

Parametrised successor to the single-bit D/T flip-flop benchmark cells. It provides CHANNELS independent WIDTH-bit registers, each with a runtime-selectable mode: load, toggle, shift or hold. Each channel has a per-channel enable and a configurable output delay pipeline. A registered cross-channel AND reduction drives the block-level timing endpoint. The block sits in the benchmark netlists as the generic register source for multi-path timing constraints.

---
 rtl/multi_mode_reg_pkg.sv | 12 +
 rtl/multi_mode_reg_array_channel.sv | 75 +++++++
 rtl/multi_mode_reg_array.sv | 75 +++++++
 3 files changed

// File: rtl/multi_mode_reg_pkg.sv
// Shared definitions for the multi-mode register array: the encoding of the
// 2-bit per-channel mode field.
package multi_mode_reg_pkg;

   typedef logic [1:0] mode_t;

   localparam mode_t MODE_LOAD   = 2'b00;
   localparam mode_t MODE_TOGGLE = 2'b01;
   localparam mode_t MODE_SHIFT  = 2'b10;
   localparam mode_t MODE_HOLD   = 2'b11;

endpackage

// File: rtl/multi_mode_reg_array_channel.sv
// One register channel: a WIDTH-bit core register with a load/toggle/shift/hold
// mode mux and enable, followed by a DEPTH-stage output delay pipeline.
module reg_channel
   import multi_mode_reg_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  mode_t            mode,
   input  logic [WIDTH-1:0] d,
   input  logic             sin,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] r;
   logic [WIDTH-1:0] r_next;
   logic [WIDTH-1:0] r_shift;

   // A one-bit register has nothing to shift along, so it just takes sin.
   generate
      if (WIDTH == 1) begin : g_shift_1
         assign r_shift = sin;
      end else begin : g_shift_n
         assign r_shift = {r[WIDTH-2:0], sin};
      end
   endgenerate

   // Mode mux: selects the next core value; d and sin are only looked at
   // when the channel is enabled in a mode that uses them.
   always_comb begin
      // NOTE: assigning the hold value first gives every path a value, so no latch is inferred.
      r_next = r;
      if (en) begin
         case (mode)
            MODE_LOAD:   r_next = d;
            MODE_TOGGLE: r_next = r ^ d;
            MODE_SHIFT:  r_next = r_shift;
            default:     r_next = r;
         endcase
      end
   end

   // Core register with synchronous clear.
   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
      if (reset) r <= '0;
      else       r <= r_next;
   end

   // Output delay line; free-running, not gated by en.
   generate
      if (DEPTH == 0) begin : g_no_pipe
         assign q = r;
      end else begin : g_pipe
         logic [WIDTH-1:0] stage [DEPTH];

         // Shift register of DEPTH stages behind the core register.
         always_ff @(posedge clk) begin
            // NOTE: this storage array is cleared on reset on purpose: a reset must discard in-flight data.
            if (reset) begin
               for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
            end else begin
               stage[0] <= r;
               for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
            end
         end

         assign q = stage[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/multi_mode_reg_array.sv
// Top level of the multi-mode register array: CHANNELS independent register
// channels plus a registered cross-channel AND reduction (q_and).
// Optional feature macro MULTI_MODE_REG_PARITY_EN adds a registered per-channel
// parity output q_par aligned with q_and.
module multi_mode_reg_array
   import multi_mode_reg_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int DEPTH    = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [CHANNELS-1:0]       en,
   input  logic [2*CHANNELS-1:0]     mode,
   input  logic [CHANNELS*WIDTH-1:0] d,
   input  logic [CHANNELS-1:0]       sin,
   output logic [CHANNELS*WIDTH-1:0] q,
   output logic [WIDTH-1:0]          q_and
`ifdef MULTI_MODE_REG_PARITY_EN
   ,
   output logic [CHANNELS-1:0]       q_par
`endif
);

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      reg_channel #(
         .WIDTH (WIDTH),
         .DEPTH (DEPTH)
      ) u_ch (
         .clk   (clk),
         .reset (reset),
         .en    (en[c]),
         .mode  (mode[2*c +: 2]),
         .d     (d[WIDTH*c +: WIDTH]),
         .sin   (sin[c]),
         .q     (q[WIDTH*c +: WIDTH])
      );
   end

   logic [WIDTH-1:0] and_all;

   // Bitwise AND of every channel's delayed output.
   always_comb begin
      and_all = '1;
      for (int c = 0; c < CHANNELS; c++) begin
         and_all = and_all & q[WIDTH*c +: WIDTH];
      end
   end

   // Registered reduction that drives the block-level timing endpoint.
   always_ff @(posedge clk) begin
      if (reset) q_and <= '0;
      else       q_and <= and_all;
   end

`ifdef MULTI_MODE_REG_PARITY_EN
   logic [CHANNELS-1:0] par_next;

   // Per-channel XOR reduction of q.
   always_comb begin
      par_next = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         par_next[c] = ^q[WIDTH*c +: WIDTH];
      end
   end

   // Parity register, same latency as q_and.
   always_ff @(posedge clk) begin
      if (reset) q_par <= '0;
      else       q_par <= par_next;
   end
`endif

endmodule
